// File: rtl/attractor_event_monitor.sv
// -----------------------------------------------------------------------------
// attractor_event_monitor
//
// Watches the per-oscillator 2-bit position class coming from the
// quarter-integer classifier. It tracks how long each lane stays in its
// class and reports two kinds of event over a valid/ready stream:
//   TRANSITION : a lane changed class  {old class, new class, dwell in old}
//   ESCAPE     : a lane has stayed DANGER_LIMIT samples in class 11
// It also holds an escape_active level while a lane remains in class 11
// after its ESCAPE has fired.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   clk_en                 sample strobe shared with the classifier
//   position_class_packed  lane i class at [2i+1:2i]
//                          (00 int, 01 half, 10 quarter, 11 near-catastrophe)
//   evt_valid/evt_ready    event stream handshake
//   evt_type               0 = TRANSITION, 1 = ESCAPE
//   evt_osc                lane index of the event
//   evt_old_class/new      classes before/after (ESCAPE: 11/11)
//   evt_dwell              TRANSITION: samples in old class; ESCAPE: DANGER_LIMIT
//   escape_active          per-lane escape level
//   overflow_count         saturating count of overwritten pending TRANSITIONs
// -----------------------------------------------------------------------------
module attractor_event_monitor #(
    parameter int NUM_OSCILLATORS = 21,
    parameter int IDX_W           = 5,
    parameter int DWELL_W         = 12,
    parameter int DANGER_LIMIT    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic [2*NUM_OSCILLATORS-1:0] position_class_packed,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic                         evt_type,
    output logic [IDX_W-1:0]             evt_osc,
    output logic [1:0]                   evt_old_class,
    output logic [1:0]                   evt_new_class,
    output logic [DWELL_W-1:0]           evt_dwell,
    output logic [NUM_OSCILLATORS-1:0]   escape_active,
    output logic [7:0]                   overflow_count
);

    localparam int N     = NUM_OSCILLATORS;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};
    localparam logic [DWELL_W-1:0] LIMIT     = DWELL_W'(DANGER_LIMIT);

    // Per-lane tracking state
    logic                primed;
    logic [1:0]          prev_class [N];
    logic [DWELL_W-1:0]  dwell      [N];
    logic [N-1:0]        trans_pend;
    logic [N-1:0]        esc_pend;

    // Per-lane TRANSITION snapshot, valid while trans_pend[i] is set
    logic [1:0]          snap_old   [N];
    logic [1:0]          snap_new   [N];
    logic [DWELL_W-1:0]  snap_dwell [N];

    // Combinational per-lane decode
    logic [1:0]          cur_class  [N];
    logic [DWELL_W-1:0]  dwell_next [N];
    logic [N-1:0]        trans_set;
    logic [N-1:0]        esc_set;

    // Drain selection
    logic                load_en;
    logic                found_esc;
    logic                found_trans;
    logic [IDX_W-1:0]    esc_idx;
    logic [IDX_W-1:0]    trans_idx;
    logic [N-1:0]        drain_esc;
    logic [N-1:0]        drain_trans;
    logic [CNT_W-1:0]    ovf_hits;
    logic [8:0]          ovf_sum;
    logic [7:0]          ovf_next;

    // Sample decode: what each lane would do if clk_en is high this cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        for (int i = 0; i < N; i++) begin
            cur_class[i]  = position_class_packed[2*i +: 2];
            dwell_next[i] = DWELL_ONE;
            trans_set[i]  = 1'b0;
            esc_set[i]    = 1'b0;
            if (primed) begin
                if (cur_class[i] != prev_class[i]) begin
                    dwell_next[i] = DWELL_ONE;
                    trans_set[i]  = clk_en;
                end else begin
                    dwell_next[i] = (dwell[i] == DWELL_MAX) ? dwell[i] : dwell[i] + DWELL_ONE;
                end
                // The extra term stops a saturated counter that sits at the
                // limit from re-firing: ESCAPE happens once per zone entry.
                esc_set[i] = clk_en && (cur_class[i] == 2'b11) && (dwell_next[i] == LIMIT) &&
                             ((cur_class[i] != prev_class[i]) || (dwell[i] != LIMIT));
            end
        end
    end

    // Drain: lowest-index ESCAPE first, then lowest-index TRANSITION.
    always_comb begin
        load_en     = !evt_valid || evt_ready;
        found_esc   = 1'b0;
        found_trans = 1'b0;
        esc_idx     = '0;
        trans_idx   = '0;
        drain_esc   = '0;
        drain_trans = '0;
        ovf_hits    = '0;
        // Scanning downwards lets the lowest set index win.
        for (int i = N - 1; i >= 0; i--) begin
            if (esc_pend[i]) begin
                found_esc = 1'b1;
                esc_idx   = IDX_W'(i);
            end
            if (trans_pend[i]) begin
                found_trans = 1'b1;
                trans_idx   = IDX_W'(i);
            end
        end
        if (load_en) begin
            if (found_esc) begin
                drain_esc[esc_idx] = 1'b1;
            end else if (found_trans) begin
                drain_trans[trans_idx] = 1'b1;
            end
        end
        // A new snapshot landing on an undrained pending one loses the old one.
        for (int i = 0; i < N; i++) begin
            if (trans_set[i] && trans_pend[i] && !drain_trans[i]) begin
                ovf_hits = ovf_hits + CNT_W'(1);
            end
        end
        ovf_sum  = {1'b0, overflow_count} + 9'(ovf_hits);
        ovf_next = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    end

    // Tracking state, pending flags and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed         <= 1'b0;
            trans_pend     <= '0;
            esc_pend       <= '0;
            escape_active  <= '0;
            overflow_count <= '0;
            evt_valid      <= 1'b0;
            evt_type       <= 1'b0;
            evt_osc        <= '0;
            evt_old_class  <= '0;
            evt_new_class  <= '0;
            evt_dwell      <= '0;
            for (int i = 0; i < N; i++) begin
                prev_class[i] <= '0;
                dwell[i]      <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            // A set in the same cycle as a drain keeps the bit up for the new snapshot.
            trans_pend     <= (trans_pend & ~drain_trans) | trans_set;
            esc_pend       <= (esc_pend & ~drain_esc) | esc_set;
            overflow_count <= ovf_next;

            if (clk_en) begin
                primed <= 1'b1;
                for (int i = 0; i < N; i++) begin
                    prev_class[i] <= cur_class[i];
                    dwell[i]      <= dwell_next[i];
                    if (primed) begin
                        escape_active[i] <= (cur_class[i] == 2'b11) && (escape_active[i] || esc_set[i]);
                    end
                end
            end

            if (load_en) begin
                if (found_esc) begin
                    evt_valid     <= 1'b1;
                    evt_type      <= 1'b1;
                    evt_osc       <= esc_idx;
                    evt_old_class <= 2'b11;
                    evt_new_class <= 2'b11;
                    evt_dwell     <= LIMIT;
                end else if (found_trans) begin
                    evt_valid     <= 1'b1;
                    evt_type      <= 1'b0;
                    evt_osc       <= trans_idx;
                    evt_old_class <= snap_old[trans_idx];
                    evt_new_class <= snap_new[trans_idx];
                    evt_dwell     <= snap_dwell[trans_idx];
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

    // NOTE: snapshots are only read while their pending bit is set and those bits are reset, so this storage carries no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (trans_set[i]) begin
                snap_old[i]   <= prev_class[i];
                snap_new[i]   <= cur_class[i];
                snap_dwell[i] <= dwell[i];
            end
        end
    end

endmodule
